// File: rtl/seg7_pkg.sv
// Shared constants and scan-state encoding for the multiplexed 7-segment display scanner.
// Also holds the default digit count and timing used by seg7_scan_ctrl.
package seg7_pkg;

    localparam int NDIG_DEF  = 3;
    localparam int DWELL_DEF = 8192;
    localparam int BLANK_DEF = 64;

    localparam logic [6:0]  SEG_OFF = 7'h7F;
    // Wide enough for any practical digit count; users truncate to NDIG bits.
    localparam logic [31:0] CA_NONE = '1;

    typedef logic [0:0] scan_state_t;
    localparam scan_state_t ST_SHOW  = 1'b0;
    localparam scan_state_t ST_BLANK = 1'b1;

endpackage

// File: rtl/h27seg.sv
// Hex nibble to active-low {g,f,e,d,c,b,a} segment decoder, purely combinational.
module h27seg
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: every path assigns seg first, so no latch can be inferred.
        seg = SEG_OFF;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scan scheduler for a multiplexed common-anode display: digit sequencing, blanking,
// PWM brightness and frame-aligned value updates. Outputs are registered from next-state.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NDIG  = NDIG_DEF,
    parameter int DWELL = DWELL_DEF,
    parameter int BLANK = BLANK_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_valid,
    input  logic [4*NDIG-1:0] wr_data,
    input  logic [NDIG-1:0]   wr_dp,
    output logic              wr_ready,
    input  logic [3:0]        bright,
    output logic [NDIG-1:0]   ca,
    output logic [6:0]        s7,
    output logic              dp,
    output logic              frame
);

    localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    scan_state_t       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              started_q, started_d;
    logic [3:0]        pwm_q, pwm_d;
    logic [4*NDIG-1:0] shadow_q, shadow_d, pend_q, pend_d;
    logic [NDIG-1:0]   shadow_dp_q, shadow_dp_d, pend_dp_q, pend_dp_d;
    logic              wr_ready_q, wr_ready_d;
    logic [NDIG-1:0]   ca_q, ca_d;
    logic [6:0]        s7_q, s7_d;
    logic              dp_q, dp_d, frame_q, frame_d;
    logic              wrap, xfer, commit, lit;
    logic [3:0]        nib;
    logic [6:0]        seg;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        idx_d     = idx_q;
        started_d = started_q;
        wrap      = 1'b0;
        case (state_q)
            ST_SHOW: begin
                if (cnt_q == CW'(DWELL - 1)) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == CW'(BLANK - 1)) begin
                    state_d   = ST_SHOW;
                    cnt_d     = '0;
                    started_d = 1'b1;
                    // The blank after reset leads straight into digit 0 without a frame.
                    if (!started_q) begin
                        idx_d = '0;
                    end else if (idx_q == IW'(NDIG - 1)) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        xfer        = wr_valid && wr_ready_q;
        commit      = wrap && !wr_ready_q;
        shadow_d    = commit ? pend_q : shadow_q;
        shadow_dp_d = commit ? pend_dp_q : shadow_dp_q;
        pend_d      = xfer ? wr_data : pend_q;
        pend_dp_d   = xfer ? wr_dp : pend_dp_q;
        wr_ready_d  = commit ? 1'b1 : (xfer ? 1'b0 : wr_ready_q);

        // pwm_q is the duty phase of the cycle now on the pins; pwm_d is the next one.
        pwm_d   = pwm_q + {3'b000, state_q == ST_SHOW};
        lit     = (state_d == ST_SHOW) && (pwm_d < bright);
        nib     = shadow_d[4*idx_d +: 4];
        ca_d    = (state_d == ST_SHOW) ? ~(NDIG'(1) << idx_d) : NDIG'(CA_NONE);
        s7_d    = lit ? seg : SEG_OFF;
        dp_d    = lit ? ~shadow_dp_d[idx_d] : 1'b1;
        frame_d = (state_d == ST_BLANK) && (cnt_d == CW'(BLANK - 1)) &&
                  (idx_d == IW'(NDIG - 1)) && started_d;
    end

    h27seg u_dec (
        .hex (nib),
        .seg (seg)
    );

    // NOTE: pending and shadow are reset too, so a write in flight at reset is discarded.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            started_q   <= 1'b0;
            pwm_q       <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            pend_q      <= '0;
            pend_dp_q   <= '0;
            wr_ready_q  <= 1'b1;
            ca_q        <= NDIG'(CA_NONE);
            s7_q        <= SEG_OFF;
            dp_q        <= 1'b1;
            frame_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            started_q   <= started_d;
            pwm_q       <= pwm_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            pend_q      <= pend_d;
            pend_dp_q   <= pend_dp_d;
            wr_ready_q  <= wr_ready_d;
            ca_q        <= ca_d;
            s7_q        <= s7_d;
            dp_q        <= dp_d;
            frame_q     <= frame_d;
        end
    end

    assign wr_ready = wr_ready_q;
    assign ca       = ca_q;
    assign s7       = s7_q;
    assign dp       = dp_q;
    assign frame    = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: a timeline model derived from the scan rules
// predicts every output each cycle, plus directed checks at notable points.
module tb_seg7_scan_ctrl;

    localparam int NDIG   = 3;
    localparam int DWELL  = 8;
    localparam int BLANK  = 2;
    localparam int SLOT   = DWELL + BLANK;
    localparam int PERIOD = NDIG * SLOT;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_valid;
    logic [11:0] wr_data;
    logic [2:0]  wr_dp;
    logic        wr_ready;
    logic [3:0]  bright;
    logic [2:0]  ca;
    logic [6:0]  s7;
    logic        dp;
    logic        frame;

    seg7_scan_ctrl #(.NDIG(NDIG), .DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_dp    (wr_dp),
        .wr_ready (wr_ready),
        .bright   (bright),
        .ca       (ca),
        .s7       (s7),
        .dp       (dp),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: cycle index since reset release and the value registers.
    int          t;
    logic [11:0] m_shadow, m_pend;
    logic [2:0]  m_sdp, m_pdp;
    logic        m_pvalid;
    logic [3:0]  bright_prev;
    logic [6:0]  seg_hi [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        t           = 0;
        m_shadow    = '0;
        m_sdp       = '0;
        m_pend      = '0;
        m_pdp       = '0;
        m_pvalid    = 1'b0;
        bright_prev = bright;
    endtask

    function automatic bit is_d2_show(input int tt);
        int k;
        if (tt < BLANK) return 1'b0;
        k = tt - BLANK;
        return ((k % PERIOD) / SLOT == 2) && ((k % SLOT) < DWELL);
    endfunction

    // Check all outputs for cycle t, advance the model with this cycle's inputs, move to next cycle.
    task automatic tick();
        int         k, ph, dig, pos, shows;
        bit         show, frm_t, lit;
        logic [3:0] pwm, nib;
        logic [2:0] e_ca;
        logic [6:0] e_s7;
        logic       e_dp;
        show = 1'b0; frm_t = 1'b0; dig = 0; shows = 0;
        if (t >= BLANK) begin
            k     = t - BLANK;
            ph    = k % PERIOD;
            dig   = ph / SLOT;
            pos   = ph % SLOT;
            show  = pos < DWELL;
            frm_t = (ph == PERIOD - 1);
            shows = (k / PERIOD) * NDIG * DWELL + dig * DWELL + (show ? pos : DWELL);
        end
        pwm  = 4'(shows % 16);
        lit  = show && (pwm < bright_prev);
        nib  = m_shadow[dig*4 +: 4];
        e_ca = show ? ~(3'b001 << dig) : 3'b111;
        e_s7 = lit ? ~seg_hi[nib] : 7'h7F;
        e_dp = lit ? ~m_sdp[dig] : 1'b1;
        check("ca", 32'(ca), 32'(e_ca));
        check("s7", 32'(s7), 32'(e_s7));
        check("dp", 32'(dp), 32'(e_dp));
        check("frame", 32'(frame), 32'(frm_t));
        check("wr_ready", 32'(wr_ready), 32'(!m_pvalid));
        if (frm_t && m_pvalid) begin
            m_shadow = m_pend;
            m_sdp    = m_pdp;
            m_pvalid = 1'b0;
        end else if (wr_valid && !m_pvalid) begin
            m_pend   = wr_data;
            m_pdp    = wr_dp;
            m_pvalid = 1'b1;
        end
        bright_prev = bright;
        @(negedge clk);
        t++;
    endtask

    task automatic run_to(input int target);
        while (t < target) tick();
    endtask

    initial begin
        bit found;
        seg_hi = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        resetn   = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_dp    = '0;
        bright   = 4'd15;
        repeat (2) @(negedge clk);
        check("rst_ca", 32'(ca), 32'h7);
        check("rst_s7", 32'(s7), 32'h7F);
        resetn = 1'b1;
        model_reset();

        // Write 1A5 with dp on digit 1; it commits at the first frame (t=31).
        wr_valid = 1'b1; wr_data = 12'h1A5; wr_dp = 3'b010;
        tick();
        wr_valid = 1'b0;
        run_to(31);
        check("f0_frame", 32'(frame), 32'h1);
        check("f0_ready_low", 32'(wr_ready), 32'h0);
        tick();
        check("d0_ca", 32'(ca), 32'h6);
        check("d0_s7", 32'(s7), 32'h12);
        check("d0_dp", 32'(dp), 32'h1);
        check("ready_back", 32'(wr_ready), 32'h1);
        run_to(40);
        check("blank_ca", 32'(ca), 32'h7);
        check("blank_s7", 32'(s7), 32'h7F);
        run_to(42);
        check("d1_ca", 32'(ca), 32'h5);
        check("d1_s7", 32'(s7), 32'h08);
        check("d1_dp", 32'(dp), 32'h0);
        run_to(52);
        check("d2_ca", 32'(ca), 32'h3);
        check("d2_s7", 32'(s7), 32'h79);
        run_to(60);
        check("no_frame_early", 32'(frame), 32'h0);
        run_to(61);
        check("frame_period", 32'(frame), 32'h1);

        // Write 123 during digit 1; a second offer is held until wr_ready returns.
        run_to(72);
        wr_valid = 1'b1; wr_data = 12'h123; wr_dp = 3'b000;
        tick();
        wr_data = 12'hBEE; wr_dp = 3'b101;
        run_to(91);
        check("hold_ready_low", 32'(wr_ready), 32'h0);
        tick();
        check("new_d0_s7", 32'(s7), 32'h30);
        check("ready_at_92", 32'(wr_ready), 32'h1);
        tick();
        wr_valid = 1'b0;
        check("second_taken", 32'(wr_ready), 32'h0);

        // Brightness: 4/16 duty, then fully dark while anodes keep scanning.
        bright = 4'd4;
        run_to(122);
        check("pwm_on", 32'(s7), 32'h06);
        run_to(126);
        check("pwm_off", 32'(s7), 32'h7F);
        check("pwm_off_ca", 32'(ca), 32'h6);
        run_to(150);
        bright = 4'd0;
        run_to(152);
        check("dark_s7", 32'(s7), 32'h7F);
        check("dark_ca", 32'(ca), 32'h6);
        run_to(160);

        // Randomised writes and brightness against the model.
        for (int i = 0; i < 300; i++) begin
            wr_valid = ($urandom_range(0, 7) == 0);
            wr_data  = 12'($urandom);
            wr_dp    = 3'($urandom);
            if (i % 16 == 0) bright = 4'($urandom_range(0, 15));
            tick();
        end

        // Reset during digit 2 with a write pending: pending value must be dropped.
        bright = 4'd15;
        found  = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_pvalid && is_d2_show(t)) begin
                found = 1'b1;
            end else begin
                wr_valid = !m_pvalid;
                wr_data  = 12'hFFF;
                wr_dp    = 3'b111;
                tick();
            end
        end
        wr_valid = 1'b0;
        check("found_d2_pending", 32'(found), 32'h1);
        resetn = 1'b0;
        #1;
        check("mid_rst_ca", 32'(ca), 32'h7);
        check("mid_rst_s7", 32'(s7), 32'h7F);
        check("mid_rst_dp", 32'(dp), 32'h1);
        check("mid_rst_frame", 32'(frame), 32'h0);
        check("mid_rst_ready", 32'(wr_ready), 32'h1);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        run_to(32);
        check("post_rst_s7", 32'(s7), 32'h40);
        run_to(100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
